dc_pid_seq: RTL and testbench

- Control sequencer for the 14-bit digital-control datapath.
- On each new sample strobe it runs one full PID update:
  - error and integral update;
  - three coefficient fetches from EEPROM into the PID register;
  - three 14-iteration Booth multiplies with saturated accumulation into the duty register.
- Sits between the A2D sample-ready logic, the EEPROM read port and the datapath control inputs.

---
 rtl/dc_pid_seq.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dc_pid_seq.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_pid_seq.sv
// dc_pid_seq: control sequencer for the 14-bit PID datapath.
// Each go strobe runs one error/integral update, then per term
// (P, I, D) a coefficient fetch, a Booth multiply and a saturated
// accumulate into the duty register.
//
// Build option: define DC_PID_DTERM_EN to run the derivative term.
// Without it the update ends after the I term and preverr is idle.
//
// Ports:
//   i_clk            clock
//   i_rst            synchronous reset, active-high
//   i_go             one-cycle sample-ready strobe
//   i_c_prod[1:0]    datapath prod[1:0] (Booth pair)
//   i_eep_rd_vld     EEPROM read data valid
//   o_eep_rd_req     EEPROM read request
//   o_eep_addr[1:0]  EEPROM read address
//   o_c_asel[2:0]    A-mux select
//   o_c_bsel[2:0]    B-mux select
//   o_c_err .. o_c_pid  datapath register enables
//   o_c_init_prod, o_c_subtract, o_c_multsat,
//   o_c_clr_duty, o_c_eep_reg  datapath controls
//   o_busy           update in progress
//   o_done           one-cycle pulse, update complete
//   o_ovr            one-cycle pulse, go dropped
module dc_pid_seq #(
   parameter logic [1:0] ADDR_XSET = 2'd0,
   parameter logic [1:0] ADDR_KP   = 2'd1,
   parameter logic [1:0] ADDR_KI   = 2'd2,
   parameter logic [1:0] ADDR_KD   = 2'd3,
   parameter int         MULT_ITER = 14
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_go,
   input  logic [1:0] i_c_prod,
   input  logic       i_eep_rd_vld,
   output logic       o_eep_rd_req,
   output logic [1:0] o_eep_addr,
   output logic [2:0] o_c_asel,
   output logic [2:0] o_c_bsel,
   output logic       o_c_err,
   output logic       o_c_duty,
   output logic       o_c_sumerr,
   output logic       o_c_xset,
   output logic       o_c_preverr,
   output logic       o_c_pid,
   output logic       o_c_init_prod,
   output logic       o_c_subtract,
   output logic       o_c_multsat,
   output logic       o_c_clr_duty,
   output logic       o_c_eep_reg,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_ovr
);

   localparam int CW = $clog2(MULT_ITER);
   localparam logic [CW-1:0] LAST_IT =
      CW'(MULT_ITER - 1);

   localparam logic [2:0] A_XMEAS = 3'd1;
   localparam logic [2:0] A_ERR   = 3'd2;
   localparam logic [2:0] A_PROD  = 3'd3;
   localparam logic [2:0] A_DUTY  = 3'd4;
   localparam logic [2:0] A_ZERO  = 3'd7;

   localparam logic [2:0] B_XSET  = 3'd0;
   localparam logic [2:0] B_SUM   = 3'd1;
   localparam logic [2:0] B_PREV  = 3'd2;
   localparam logic [2:0] B_ZERO  = 3'd3;
   localparam logic [2:0] B_PID   = 3'd4;

   typedef enum logic [3:0] {
      S_CLR,
      S_FXS,
      S_IDLE,
      S_ERR,
      S_SUM,
      S_FK,
      S_LD,
      S_BOOTH,
      S_SAT,
      S_ACC,
      S_PREV
   } state_t;

   typedef enum logic [1:0] {
      T_P,
      T_I,
      T_D
   } term_t;

   state_t        r_state;
   state_t        w_state_nxt;
   term_t         r_term;
   term_t         w_term_nxt;
   logic          r_pending;
   logic          w_pending_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    w_kaddr;
   logic          w_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_CLR;
         r_term    <= T_P;
         r_pending <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_term    <= w_term_nxt;
         r_pending <= w_pending_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign w_kaddr = (r_term == T_P) ? ADDR_KP :
                    (r_term == T_I) ? ADDR_KI :
                                      ADDR_KD;

`ifdef DC_PID_DTERM_EN
   assign w_last = (r_term == T_D);
`else
   assign w_last = (r_term == T_I);
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_term_nxt    = r_term;
      w_pending_nxt = r_pending;
      w_cnt_nxt     = r_cnt;
      o_eep_rd_req  = 1'b0;
      o_eep_addr    = ADDR_XSET;
      o_c_asel      = A_ZERO;
      o_c_bsel      = B_ZERO;
      o_c_err       = 1'b0;
      o_c_duty      = 1'b0;
      o_c_sumerr    = 1'b0;
      o_c_xset      = 1'b0;
      o_c_preverr   = 1'b0;
      o_c_pid       = 1'b0;
      o_c_init_prod = 1'b0;
      o_c_subtract  = 1'b0;
      o_c_multsat   = 1'b0;
      o_c_clr_duty  = 1'b0;
      o_c_eep_reg   = 1'b0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_ovr         = 1'b0;

      // One strobe may queue behind a running update;
      // a further one is dropped and flagged.
      if (i_go && (r_state != S_IDLE)) begin
         if (r_pending) begin
            o_ovr = 1'b1;
         end else begin
            w_pending_nxt = 1'b1;
         end
      end

      unique case (r_state)
         S_CLR: begin
            o_c_clr_duty = 1'b1;
            o_c_sumerr   = 1'b1;
`ifdef DC_PID_DTERM_EN
            o_c_preverr  = 1'b1;
`endif
            w_state_nxt  = S_FXS;
         end
         S_FXS: begin
            o_eep_rd_req = 1'b1;
            o_eep_addr   = ADDR_XSET;
            if (i_eep_rd_vld) begin
               o_c_eep_reg = 1'b1;
               o_c_xset    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (i_go || r_pending) begin
               w_pending_nxt = 1'b0;
               w_term_nxt    = T_P;
               w_state_nxt   = S_ERR;
            end
         end
         S_ERR: begin
            o_busy       = 1'b1;
            o_c_asel     = A_XMEAS;
            o_c_bsel     = B_XSET;
            o_c_subtract = 1'b1;
            o_c_err      = 1'b1;
            w_state_nxt  = S_SUM;
         end
         S_SUM: begin
            o_busy      = 1'b1;
            o_c_asel    = A_ERR;
            o_c_bsel    = B_SUM;
            o_c_sumerr  = 1'b1;
            w_state_nxt = S_FK;
         end
         S_FK: begin
            o_busy       = 1'b1;
            o_eep_rd_req = 1'b1;
            o_eep_addr   = w_kaddr;
            if (i_eep_rd_vld) begin
               o_c_eep_reg = 1'b1;
               o_c_pid     = 1'b1;
               w_state_nxt = S_LD;
            end
         end
         S_LD: begin
            o_busy        = 1'b1;
            o_c_init_prod = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_BOOTH;
            unique case (r_term)
               T_P: begin
                  o_c_asel = A_ERR;
                  o_c_bsel = B_ZERO;
               end
               T_I: begin
                  o_c_asel = A_ZERO;
                  o_c_bsel = B_SUM;
               end
               default: begin
                  o_c_asel     = A_ERR;
                  o_c_bsel     = B_PREV;
                  o_c_subtract = 1'b1;
               end
            endcase
         end
         S_BOOTH: begin
            o_busy   = 1'b1;
            o_c_asel = A_PROD;
            unique case (i_c_prod)
               2'b01: o_c_bsel = B_PID;
               2'b10: begin
                  o_c_bsel     = B_PID;
                  o_c_subtract = 1'b1;
               end
               default: o_c_bsel = B_ZERO;
            endcase
            // prod shifts every cycle, so SAT must follow
            // the last iteration with no gap.
            if (r_cnt == LAST_IT) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_SAT;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_SAT: begin
            o_busy      = 1'b1;
            o_c_asel    = A_PROD;
            o_c_bsel    = B_ZERO;
            o_c_multsat = 1'b1;
            // P seeds duty directly; later terms add to it.
            if (r_term == T_P) begin
               o_c_duty    = 1'b1;
               w_term_nxt  = T_I;
               w_state_nxt = S_FK;
            end else begin
               o_c_pid     = 1'b1;
               w_state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            o_busy   = 1'b1;
            o_c_asel = A_DUTY;
            o_c_bsel = B_PID;
            o_c_duty = 1'b1;
            if (w_last) begin
`ifdef DC_PID_DTERM_EN
               w_state_nxt = S_PREV;
`else
               o_done      = 1'b1;
               w_state_nxt = S_IDLE;
`endif
            end else begin
               w_term_nxt  = T_D;
               w_state_nxt = S_FK;
            end
         end
         S_PREV: begin
            o_busy      = 1'b1;
            o_c_asel    = A_ERR;
            o_c_bsel    = B_ZERO;
            o_c_preverr = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_CLR;
         end
      endcase
   end

endmodule

// File: tb/tb_dc_pid_seq.sv
// tb_dc_pid_seq: randomized bench for dc_pid_seq with a
// datapath/EEPROM model and an arithmetic PID reference.
module tb_dc_pid_seq;

`ifdef DC_PID_DTERM_EN
   localparam int LAT = 56;
   localparam logic [13:0] EXP_D1 = 14'h00C0;
   localparam logic [13:0] EXP_PV = 14'h0100;
`else
   localparam int LAT = 37;
   localparam logic [13:0] EXP_D1 = 14'h0040;
   localparam logic [13:0] EXP_PV = 14'h0000;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go  = 1'b0;
   logic [1:0] prod;
   logic       w_vld;
   logic       o_eep_rd_req;
   logic [1:0] o_eep_addr;
   logic [2:0] o_c_asel;
   logic [2:0] o_c_bsel;
   logic       o_c_err, o_c_duty, o_c_sumerr;
   logic       o_c_xset, o_c_preverr, o_c_pid;
   logic       o_c_init_prod, o_c_subtract;
   logic       o_c_multsat, o_c_clr_duty;
   logic       o_c_eep_reg;
   logic       o_busy, o_done, o_ovr;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   dc_pid_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_go         (go),
      .i_c_prod     (prod),
      .i_eep_rd_vld (w_vld),
      .o_eep_rd_req (o_eep_rd_req),
      .o_eep_addr   (o_eep_addr),
      .o_c_asel     (o_c_asel),
      .o_c_bsel     (o_c_bsel),
      .o_c_err      (o_c_err),
      .o_c_duty     (o_c_duty),
      .o_c_sumerr   (o_c_sumerr),
      .o_c_xset     (o_c_xset),
      .o_c_preverr  (o_c_preverr),
      .o_c_pid      (o_c_pid),
      .o_c_init_prod(o_c_init_prod),
      .o_c_subtract (o_c_subtract),
      .o_c_multsat  (o_c_multsat),
      .o_c_clr_duty (o_c_clr_duty),
      .o_c_eep_reg  (o_c_eep_reg),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_ovr        (o_ovr)
   );

   function automatic longint sat14(input longint v);
      if (v > 8191) return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   // EEPROM: answers after dly[addr] waiting cycles.
   logic signed [13:0] mem [4];
   int dly [4];
   int wcnt = 0;
   assign w_vld = o_eep_rd_req && (wcnt >= dly[o_eep_addr]);

   always @(posedge clk) begin
      if (o_eep_rd_req && !w_vld) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   // Datapath model driven by the sequencer's controls.
   logic signed [13:0] xmeas;
   logic signed [13:0] d_xset, d_err, d_sumerr;
   logic signed [13:0] d_preverr = '0;
   logic signed [13:0] d_pid, d_duty, d_mreg;
   logic               d_mprev;
   longint             d_acc;
   int                 d_k;
   longint             dp_a, dp_b, dp_r, dp_t;
   logic signed [13:0] dp_s;

   assign prod = {d_mreg[0], d_mprev};

   always_comb begin
      dp_a = 0;
      dp_b = 0;
      case (o_c_asel)
         3'd1: dp_a = longint'(xmeas);
         3'd2: dp_a = longint'(d_err);
         3'd4: dp_a = longint'(d_duty);
         default: dp_a = 0;
      endcase
      case (o_c_bsel)
         3'd0: dp_b = longint'(d_xset);
         3'd1: dp_b = longint'(d_sumerr);
         3'd2: dp_b = longint'(d_preverr);
         3'd4: dp_b = longint'(d_pid);
         default: dp_b = 0;
      endcase
      dp_r = o_c_subtract ? dp_a - dp_b : dp_a + dp_b;
      if (o_c_multsat) dp_r = d_acc >>> 14;
      dp_s = 14'(sat14(dp_r));
      dp_t = longint'(d_pid) <<< d_k;
   end

   always @(posedge clk) begin
      if (o_c_clr_duty) d_duty <= '0;
      else if (o_c_duty) d_duty <= dp_s;
      if (o_c_xset) d_xset <= mem[o_eep_addr];
      if (o_c_err) d_err <= dp_s;
      if (o_c_sumerr) d_sumerr <= dp_s;
      if (o_c_preverr) d_preverr <= dp_s;
      if (o_c_pid)
         d_pid <= o_c_eep_reg ? mem[o_eep_addr] : dp_s;
      if (o_c_init_prod) begin
         d_mreg  <= dp_s;
         d_mprev <= 1'b0;
         d_acc   <= 0;
         d_k     <= 0;
      end else if (o_c_asel == 3'd3 && !o_c_multsat) begin
         if (o_c_bsel == 3'd4)
            d_acc <= o_c_subtract ? d_acc - dp_t : d_acc + dp_t;
         d_mreg  <= d_mreg >>> 1;
         d_mprev <= d_mreg[0];
         d_k     <= d_k + 1;
      end
   end

   // Event counters.
   int done_cnt = 0;
   int ovr_cnt  = 0;
   int fxs_rd   = 0;
   int kd_rd    = 0;

   always @(negedge clk) begin
      if (o_done) done_cnt <= done_cnt + 1;
      if (o_ovr) ovr_cnt <= ovr_cnt + 1;
      if (o_eep_rd_req && w_vld && !o_busy && o_eep_addr == 2'd0)
         fxs_rd <= fxs_rd + 1;
      if (o_eep_rd_req && o_eep_addr == 2'd3)
         kd_rd <= kd_rd + 1;
   end

   // Reference: one PID update in plain arithmetic.
   longint r_xset, r_err, r_sum, r_prev, r_duty;

   function automatic void ref_reset();
      r_sum  = 0;
      r_prev = 0;
      r_duty = 0;
      r_xset = longint'(mem[0]);
   endfunction

   function automatic void ref_update();
      longint p, i, dd, d;
      r_err  = sat14(longint'(xmeas) - r_xset);
      r_sum  = sat14(r_sum + r_err);
      p      = sat14((r_err * longint'(mem[1])) >>> 14);
      i      = sat14((r_sum * longint'(mem[2])) >>> 14);
      r_duty = sat14(p + i);
`ifdef DC_PID_DTERM_EN
      dd     = sat14(r_err - r_prev);
      d      = sat14((dd * longint'(mem[3])) >>> 14);
      r_duty = sat14(r_duty + d);
      r_prev = r_err;
`else
      dd = 0;
      d  = dd;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      go  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      ref_reset();
   endtask

   task automatic run_update(output int lat, output int bc);
      lat = -1;
      bc  = 0;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         if (o_busy) bc++;
         if (o_done) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      int f0;
      mem[0] = 14'h0100;
      mem[1] = '0;
      mem[2] = '0;
      mem[3] = '0;
      for (int i = 0; i < 4; i++) dly[i] = 0;
      xmeas = '0;
      f0 = fxs_rd;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if ({o_busy, o_done, o_ovr, o_eep_rd_req} !== 4'b0) begin
         err_cnt++;
         $display("FAIL rst_outs act=%b exp=0000",
                  {o_busy, o_done, o_ovr, o_eep_rd_req});
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      ref_reset();
      vec_cnt++;
      if (fxs_rd - f0 !== 1) begin
         err_cnt++;
         $display("FAIL fxs_reads act=%0d exp=1", fxs_rd - f0);
      end
      vec_cnt++;
      if (d_xset !== 14'h0100) begin
         err_cnt++;
         $display("FAIL xset act=%h exp=0100", d_xset);
      end
      vec_cnt++;
      if ({d_duty, d_sumerr, d_preverr} !== 42'b0) begin
         err_cnt++;
         $display("FAIL rst_regs duty=%h sum=%h prev=%h exp=0",
                  d_duty, d_sumerr, d_preverr);
      end
      vec_cnt++;
      if (o_busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_busy act=%b exp=0", o_busy);
      end
   endtask

   task automatic test_kp();
      int lat, bc, o0;
      mem[1] = 14'h1000;
      mem[2] = '0;
      mem[3] = '0;
      xmeas  = 14'h0200;
      o0 = ovr_cnt;
      run_update(lat, bc);
      ref_update();
      vec_cnt++;
      if (lat !== LAT) begin
         err_cnt++;
         $display("FAIL kp_latency act=%0d exp=%0d", lat, LAT);
      end
      vec_cnt++;
      if (bc !== LAT) begin
         err_cnt++;
         $display("FAIL kp_busy act=%0d exp=%0d", bc, LAT);
      end
      vec_cnt++;
      if (d_err !== 14'h0100) begin
         err_cnt++;
         $display("FAIL kp_err act=%h exp=0100", d_err);
      end
      vec_cnt++;
      if (d_duty !== 14'h0040) begin
         err_cnt++;
         $display("FAIL kp_duty act=%h exp=0040", d_duty);
      end
      vec_cnt++;
      if (ovr_cnt - o0 !== 0) begin
         err_cnt++;
         $display("FAIL kp_ovr act=%0d exp=0", ovr_cnt - o0);
      end
   endtask

   task automatic test_dterm();
      int lat, bc, k0;
      mem[0] = 14'h0100;
      do_reset();
      mem[1] = 14'h1000;
      mem[2] = '0;
      mem[3] = 14'h2000;
      xmeas  = 14'h0200;
      k0 = kd_rd;
      run_update(lat, bc);
      ref_update();
      vec_cnt++;
      if (d_duty !== EXP_D1) begin
         err_cnt++;
         $display("FAIL dterm_duty1 act=%h exp=%h", d_duty, EXP_D1);
      end
      run_update(lat, bc);
      ref_update();
      vec_cnt++;
      if (d_duty !== 14'h0040) begin
         err_cnt++;
         $display("FAIL dterm_duty2 act=%h exp=0040", d_duty);
      end
      vec_cnt++;
      if (d_preverr !== EXP_PV) begin
         err_cnt++;
         $display("FAIL dterm_prev act=%h exp=%h", d_preverr, EXP_PV);
      end
`ifndef DC_PID_DTERM_EN
      vec_cnt++;
      if (kd_rd - k0 !== 0) begin
         err_cnt++;
         $display("FAIL kd_reads act=%0d exp=0", kd_rd - k0);
      end
`endif
   endtask

   task automatic test_integral();
      int lat, bc;
      logic [13:0] es, ed;
      mem[0] = 14'h0100;
      do_reset();
      mem[1] = '0;
      mem[2] = 14'h1000;
      mem[3] = '0;
      xmeas  = 14'h0200;
      for (int k = 1; k <= 3; k++) begin
         run_update(lat, bc);
         ref_update();
         es = 14'(k * 'h100);
         ed = 14'(k * 'h40);
         vec_cnt++;
         if (d_sumerr !== es) begin
            err_cnt++;
            $display("FAIL int_sum%0d act=%h exp=%h", k, d_sumerr, es);
         end
         vec_cnt++;
         if (d_duty !== ed) begin
            err_cnt++;
            $display("FAIL int_duty%0d act=%h exp=%h", k, d_duty, ed);
         end
      end
   endtask

   task automatic test_random();
      int lat, bc;
      mem[0] = 14'($urandom);
      do_reset();
      for (int k = 0; k < 10; k++) begin
         for (int a = 1; a < 4; a++) begin
            mem[a] = 14'($urandom);
            if ($urandom_range(0, 1) == 1)
               mem[a] = mem[a] >>> $urandom_range(1, 6);
            dly[a] = $urandom_range(0, 3);
         end
         xmeas = 14'($urandom);
         run_update(lat, bc);
         ref_update();
         vec_cnt++;
         if (d_duty !== 14'(r_duty) || d_sumerr !== 14'(r_sum)
             || d_err !== 14'(r_err)
             || d_preverr !== 14'(r_prev)) begin
            err_cnt++;
            $display("FAIL rand%0d duty=%h/%h sum=%h/%h prev=%h/%h",
                     k, d_duty, 14'(r_duty), d_sumerr, 14'(r_sum),
                     d_preverr, 14'(r_prev));
         end
      end
      for (int a = 0; a < 4; a++) dly[a] = 0;
   endtask

   task automatic test_pending();
      int d0, o0;
      d0 = done_cnt;
      o0 = ovr_cnt;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (done_cnt - d0 >= 2) break;
         @(negedge clk);
      end
      repeat (80) @(negedge clk);
      ref_update();
      ref_update();
      vec_cnt++;
      if (done_cnt - d0 !== 2) begin
         err_cnt++;
         $display("FAIL pend_done act=%0d exp=2", done_cnt - d0);
      end
      vec_cnt++;
      if (ovr_cnt - o0 !== 1) begin
         err_cnt++;
         $display("FAIL pend_ovr act=%0d exp=1", ovr_cnt - o0);
      end
      vec_cnt++;
      if (d_duty !== 14'(r_duty) || d_sumerr !== 14'(r_sum)) begin
         err_cnt++;
         $display("FAIL pend_regs duty=%h/%h sum=%h/%h",
                  d_duty, 14'(r_duty), d_sumerr, 14'(r_sum));
      end
   endtask

   task automatic test_back_to_back();
      int d0, o0, gap;
      d0  = done_cnt;
      o0  = ovr_cnt;
      gap = -1;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (o_done) break;
         @(negedge clk);
      end
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 1; n < 300; n++) begin
         if (o_done) begin
            gap = n;
            break;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      ref_update();
      ref_update();
      vec_cnt++;
      if (gap !== LAT + 1) begin
         err_cnt++;
         $display("FAIL b2b_gap act=%0d exp=%0d", gap, LAT + 1);
      end
      vec_cnt++;
      if (done_cnt - d0 !== 2 || ovr_cnt - o0 !== 0) begin
         err_cnt++;
         $display("FAIL b2b_cnt done=%0d ovr=%0d exp=2/0",
                  done_cnt - d0, ovr_cnt - o0);
      end
      vec_cnt++;
      if (d_duty !== 14'(r_duty)) begin
         err_cnt++;
         $display("FAIL b2b_duty act=%h exp=%h", d_duty, 14'(r_duty));
      end
   endtask

   task automatic test_fetch_rst();
      bit found;
      found  = 1'b0;
      dly[2] = 5;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (o_eep_rd_req && o_eep_addr == 2'd2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (found !== 1'b1) begin
         err_cnt++;
         $display("FAIL fki_seen act=0 exp=1");
      end
      for (int i = 0; i < 6; i++) begin
         vec_cnt++;
         if ({o_eep_rd_req, o_eep_addr, w_vld}
             !== {3'b110, (i == 5)}) begin
            err_cnt++;
            $display("FAIL fki_hold%0d act=%b exp=%b", i,
                     {o_eep_rd_req, o_eep_addr, w_vld},
                     {3'b110, (i == 5)});
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (o_c_asel !== 3'd3) begin
         err_cnt++;
         $display("FAIL booth_asel act=%0d exp=3", o_c_asel);
      end
      rst = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({o_busy, o_c_clr_duty} !== 2'b01) begin
         err_cnt++;
         $display("FAIL rst_clr act=%b exp=01",
                  {o_busy, o_c_clr_duty});
      end
      rst = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if ({o_eep_rd_req, o_eep_addr} !== 3'b100) begin
         err_cnt++;
         $display("FAIL rst_fxs act=%b exp=100",
                  {o_eep_rd_req, o_eep_addr});
      end
      repeat (5) @(negedge clk);
      ref_reset();
      vec_cnt++;
      if ({d_duty, d_sumerr, d_preverr} !== 42'b0
          || o_busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_after duty=%h sum=%h prev=%h busy=%b",
                  d_duty, d_sumerr, d_preverr, o_busy);
      end
      dly[2] = 0;
   endtask

   initial begin
      test_reset();
      test_kp();
      test_dterm();
      test_integral();
      test_random();
      test_pending();
      test_back_to_back();
      test_fetch_rst();
      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
